gate_vector_checker: RTL and testbench
======================================

Name: gate_vector_checker

Overview:
- Self-checking stimulus stage that sits directly upstream of a 2-input combinational gate (nand_gate and its siblings).
- Drives the gate's a/b inputs exhaustively through vectors 00, 01, 10, 11.
- Waits a programmable settle time, then samples the gate's result and compares it against a 4-bit truth table latched at start.
- Reports an error count and pass/fail, replacing hand-written per-gate initial-block benches.

Parameters:
- SETTLE_CYCLES, 2, cycles a vector is held before sampling; 0 is legal (sample immediately after apply).
- NUM_PASSES, 1, full 4-vector sweeps per run; minimum 1.
- CNT_W, 8, width of err_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle run request; honoured only when busy=0.
- truth_table  input  4  expected result; bit index = {a,b}; NAND = 4'b0111. Latched on accepted start.
- result_in  input  1  gate output (connects to the gate's result).
- a_out  output  1  gate input a (registered).
- b_out  output  1  gate input b (registered).
- vec_idx  output  2  current vector {a,b}.
- busy  output  1  high from the cycle after start until done.
- done  output  1  level; high after a run completes until next accepted start or reset.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  CNT_W  mismatches this run, saturating at all-ones.

Behaviour:
- Reset (async, immediate): state=IDLE; a_out=b_out=0, vec_idx=0, busy=0, done=0, pass=0, err_count=0, pass counter=0, latched table=0.
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE/DONE with start=1 at edge N:
  - truth_table latched; err_count, vec_idx and pass counter cleared; done=0; busy=1.
  - State=APPLY at N+1.
- APPLY (1 cycle): a_out/b_out = vec_idx bits.
  - Next state is SETTLE if SETTLE_CYCLES>0, else SAMPLE.
- SETTLE: exactly SETTLE_CYCLES cycles, a_out/b_out held stable, then SAMPLE.
- SAMPLE (1 cycle):
  - At the closing edge, compare result_in with table[vec_idx].
  - Mismatch: err_count += 1, unless already all-ones.
  - If vec_idx==3 and last pass: go to DONE.
  - Else if vec_idx==3: vec_idx wraps to 0, pass counter += 1, go to APPLY.
  - Else: vec_idx += 1, go to APPLY.
- Per-vector cost: SETTLE_CYCLES+2 cycles. Run length: 4*NUM_PASSES*(SETTLE_CYCLES+2) cycles from first APPLY to DONE entry.
- DONE: busy=0, done=1, pass=(err_count==0).
  - a_out/b_out/vec_idx hold their last values (3).
  - err_count holds.
- start while busy: ignored, no side effects.
- start while DONE: restarts exactly as from IDLE; done drops the following cycle.
- truth_table changes mid-run: no effect (latched copy is used).
- Reset mid-run: immediate return to reset values; no partial result retained.
- Saturation: err_count never wraps; CNT_W=2 with 4+ mismatches reads 3.

Optional Feature:
- Macro: GATE_CHK_STOP_ON_ERR_EN.
- Defined: the first mismatch in SAMPLE moves directly to DONE.
  - err_count=1, pass=0.
  - vec_idx, a_out, b_out frozen at the failing vector.
  - Remaining vectors/passes are skipped.
- Undefined: every vector of every pass is always applied and counted, as described above.

Test Plan:
- NAND correct: table=4'b0111, result_in = ~(a_out&b_out), SETTLE_CYCLES=2, NUM_PASSES=1 -> done after 16 cycles, pass=1, err_count=0, a/b sequence 00,01,10,11 each held 4 cycles.
- Stuck-at-1 fault: table=4'b0111, result_in=1 -> err_count=1 (vector 11), pass=0. With GATE_CHK_STOP_ON_ERR_EN: done after 16 cycles, vec_idx=3.
- Wrong table/multi-pass: table=4'b1000 (AND) on NAND, NUM_PASSES=2 -> err_count=8, pass=0. With GATE_CHK_STOP_ON_ERR_EN: DONE after first SAMPLE, vec_idx=0, err_count=1.
- Saturation: CNT_W=2, result_in=~table every vector, NUM_PASSES=2 -> err_count=3.
- Control:
  - start pulsed while busy -> ignored; run length unchanged.
  - start while done -> err_count cleared; done low next cycle.
  - SETTLE_CYCLES=0 -> 2 cycles per vector.
- Async reset asserted mid-SETTLE of vector 10 -> outputs zero immediately, without a clock edge. After release, IDLE; a fresh start runs a full clean sweep.

Source files
------------

// File: rtl/gate_vector_checker.sv
// -----------------------------------------------------------------------------
// gate_vector_checker
//
// Stimulus-and-check stage for a 2-input combinational gate. A run drives the
// gate inputs through {a,b} = 00, 01, 10, 11 (NUM_PASSES sweeps). Each vector
// is held for one APPLY cycle and SETTLE_CYCLES settle cycles. The gate output
// is then compared in a SAMPLE cycle against a 4-bit truth table that is
// latched when the run starts. Mismatches are counted in a saturating counter.
//
// Parameters:
//   SETTLE_CYCLES  cycles a vector is held before sampling (0 = sample at once)
//   NUM_PASSES     full 4-vector sweeps per run (>= 1)
//   CNT_W          width of err_count
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        single-cycle run request, honoured only when not busy
//   truth_table  expected gate output, bit index = {a,b} (NAND = 4'b0111)
//   result_in    gate output under test
//   a_out/b_out  registered gate inputs
//   vec_idx      current vector {a,b}
//   busy         run in progress
//   done         level, run complete (held until next accepted start/reset)
//   pass         valid with done; 1 iff err_count == 0
//   err_count    mismatches this run, saturating at all-ones
//
// Optional feature (macro GATE_CHK_STOP_ON_ERR_EN):
//   When defined, the first mismatch ends the run immediately with the vector
//   outputs frozen at the failing vector. When undefined, every vector of every
//   pass is applied and counted.
// -----------------------------------------------------------------------------
module gate_vector_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       truth_table,
  input  logic             result_in,
  output logic             a_out,
  output logic             b_out,
  output logic [1:0]       vec_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count
);

  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  localparam logic [SET_W-1:0]  SETTLE_LAST =
    SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(NUM_PASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_a_out;
  logic              r_b_out;
  logic [1:0]        r_vec_idx;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [CNT_W-1:0]  r_err_count;
  logic [3:0]        r_table;
  logic [SET_W-1:0]  r_settle_cnt;
  logic [PASS_W-1:0] r_pass_cnt;

  logic              w_mismatch;
  logic [CNT_W-1:0]  w_err_next;
  logic              w_last_vec;
  logic              w_finish;

  // Compare against the latched table so a mid-run table change has no effect.
  assign w_mismatch = (result_in != r_table[r_vec_idx]);

  // Saturating increment: an all-ones count stays all-ones.
  assign w_err_next = (w_mismatch && !(&r_err_count)) ? r_err_count + CNT_W'(1)
                                                      : r_err_count;

  assign w_last_vec = (r_vec_idx == 2'd3) && (r_pass_cnt == PASS_LAST);

`ifdef GATE_CHK_STOP_ON_ERR_EN
  assign w_finish = w_last_vec || w_mismatch;
`else
  assign w_finish = w_last_vec;
`endif

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others; the small truth-table
  // copy is an ordinary register and is reset like the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_a_out      <= 1'b0;
      r_b_out      <= 1'b0;
      r_vec_idx    <= 2'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
      r_table      <= 4'd0;
      r_settle_cnt <= '0;
      r_pass_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_table     <= truth_table;
            r_err_count <= '0;
            r_vec_idx   <= 2'd0;
            r_a_out     <= 1'b0;
            r_b_out     <= 1'b0;
            r_pass_cnt  <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_APPLY;
          end
        end

        S_APPLY: begin
          {r_a_out, r_b_out} <= r_vec_idx;
          r_settle_cnt       <= '0;
          r_state            <= (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
        end

        S_SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            r_state <= S_SAMPLE;
          end else begin
            r_settle_cnt <= r_settle_cnt + SET_W'(1);
          end
        end

        S_SAMPLE: begin
          r_err_count <= w_err_next;
          if (w_finish) begin
            // Vector outputs are left untouched so they show the last
            // (or, with stop-on-error, the failing) vector.
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
            r_state <= S_DONE;
          end else begin
            // 3 + 1 wraps to 0 in two bits, which starts the next pass.
            r_vec_idx          <= r_vec_idx + 2'd1;
            {r_a_out, r_b_out} <= r_vec_idx + 2'd1;
            if (r_vec_idx == 2'd3) begin
              r_pass_cnt <= r_pass_cnt + PASS_W'(1);
            end
            r_state <= S_APPLY;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a_out     = r_a_out;
  assign b_out     = r_b_out;
  assign vec_idx   = r_vec_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_gate_vector_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_vector_checker
//
// Directed bench for gate_vector_checker. Four instances with different
// parameter sets share clock and reset; each is fed by a small behavioural
// gate model (correct NAND, stuck-at-1, or the inverse of its table).
//   u0: SETTLE=2, PASSES=1, CNT_W=8
//   u1: SETTLE=2, PASSES=2, CNT_W=8
//   u2: SETTLE=1, PASSES=2, CNT_W=2
//   u3: SETTLE=0, PASSES=1, CNT_W=8
// -----------------------------------------------------------------------------
module tb_gate_vector_checker;

`ifdef GATE_CHK_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start_v;
  logic [3:0] res_v;
  logic [3:0] a_v;
  logic [3:0] b_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [3:0] pass_v;
  logic [1:0] vec_v [4];
  logic [3:0] tt_v  [4];
  logic [7:0] err_v [4];
  logic [1:0] err_2;
  int         mode_v [4];

  int         total = 0;
  int         bad   = 0;
  int         glitch_at  = -1;
  int         tt_swap_at = -1;
  logic [1:0] seq [64];
  int         cyc;

  always #5 clk = ~clk;

  // mode 0: NAND, 1: stuck-at-1, 2: always the inverse of the table entry
  function automatic logic gate_model(input int mode, input logic [3:0] tt,
                                      input logic a, input logic b);
    logic [1:0] idx;
    idx = {a, b};
    case (mode)
      1:       return 1'b1;
      2:       return ~tt[idx];
      default: return ~(a & b);
    endcase
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_model
    assign res_v[k] = gate_model(mode_v[k], tt_v[k], a_v[k], b_v[k]);
  end

  assign err_v[2] = 8'(err_2);

  gate_vector_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .truth_table(tt_v[0]),
    .result_in(res_v[0]), .a_out(a_v[0]), .b_out(b_v[0]), .vec_idx(vec_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]));

  gate_vector_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(2), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .truth_table(tt_v[1]),
    .result_in(res_v[1]), .a_out(a_v[1]), .b_out(b_v[1]), .vec_idx(vec_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]));

  gate_vector_checker #(.SETTLE_CYCLES(1), .NUM_PASSES(2), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .truth_table(tt_v[2]),
    .result_in(res_v[2]), .a_out(a_v[2]), .b_out(b_v[2]), .vec_idx(vec_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_2));

  gate_vector_checker #(.SETTLE_CYCLES(0), .NUM_PASSES(1), .CNT_W(8)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .truth_table(tt_v[3]),
    .result_in(res_v[3]), .a_out(a_v[3]), .b_out(b_v[3]), .vec_idx(vec_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .err_count(err_v[3]));

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Pulse start on instance k, then count edges until done (bounded by budget).
  // cycles == budget with done low shows up as a cycle-count mismatch.
  task automatic run_wait(input int k, input int budget, output int cycles);
    @(posedge clk); #1 start_v[k] = 1'b1;
    @(posedge clk); #1 start_v[k] = 1'b0;
    check("accept_busy",     32'(busy_v[k]), 1);
    check("accept_done_low", 32'(done_v[k]), 0);
    check("accept_err_clr",  32'(err_v[k]),  0);
    cycles = 0;
    while (!done_v[k] && cycles < budget) begin
      if (k == 0 && cycles < 64) seq[cycles] = {a_v[0], b_v[0]};
      start_v[k] = (cycles == glitch_at);
      if (cycles == tt_swap_at) tt_v[k] = 4'b0000;
      @(posedge clk); #1;
      cycles++;
    end
    start_v[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    start_v = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      mode_v[k] = 0;
      tt_v[k]   = 4'b0111;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_a",    32'(a_v[0]),    0);
    check("rst_b",    32'(b_v[0]),    0);
    check("rst_vec",  32'(vec_v[0]),  0);
    check("rst_busy", 32'(busy_v[0]), 0);
    check("rst_done", 32'(done_v[0]), 0);
    check("rst_pass", 32'(pass_v[0]), 0);
    check("rst_err",  32'(err_v[0]),  0);
    rst = 1'b0;

    // Correct NAND, full sweep with a/b sequence check
    run_wait(0, 100, cyc);
    check("nand_cycles", cyc, 16);
    check("nand_pass",   32'(pass_v[0]), 1);
    check("nand_err",    32'(err_v[0]),  0);
    check("nand_busy",   32'(busy_v[0]), 0);
    check("nand_vec",    32'(vec_v[0]),  3);
    check("nand_ab_hold", 32'({a_v[0], b_v[0]}), 3);
    for (int v = 0; v < 4; v++) begin
      check($sformatf("nand_seq_first_v%0d", v), 32'(seq[4*v]),     v);
      check($sformatf("nand_seq_last_v%0d", v),  32'(seq[4*v + 3]), v);
    end

    // Stuck-at-1: only vector 11 mismatches
    mode_v[0] = 1;
    run_wait(0, 100, cyc);
    check("stuck_cycles", cyc, 16);
    check("stuck_err",    32'(err_v[0]), 1);
    check("stuck_pass",   32'(pass_v[0]), 0);
    check("stuck_vec",    32'(vec_v[0]), 3);
    check("stuck_done",   32'(done_v[0]), 1);

    // Restart from DONE, start pulsed while busy, table changed mid-run
    mode_v[0]  = 0;
    glitch_at  = 5;
    tt_swap_at = 2;
    run_wait(0, 100, cyc);
    glitch_at  = -1;
    tt_swap_at = -1;
    tt_v[0]    = 4'b0111;
    check("restart_cycles", cyc, 16);
    check("restart_pass",   32'(pass_v[0]), 1);
    check("restart_err",    32'(err_v[0]),  0);

    // Wrong table (AND) against NAND, two passes
    tt_v[1] = 4'b1000;
    run_wait(1, 100, cyc);
    check("wrongtbl_cycles", cyc, STOP ? 4 : 32);
    check("wrongtbl_err",    32'(err_v[1]), STOP ? 1 : 8);
    check("wrongtbl_pass",   32'(pass_v[1]), 0);
    check("wrongtbl_vec",    32'(vec_v[1]), STOP ? 0 : 3);

    // Saturation: every vector mismatches, 2-bit counter
    tt_v[2]   = 4'b0110;
    mode_v[2] = 2;
    run_wait(2, 100, cyc);
    check("sat_cycles", cyc, STOP ? 3 : 24);
    check("sat_err",    32'(err_v[2]), STOP ? 1 : 3);
    check("sat_pass",   32'(pass_v[2]), 0);

    // Zero settle: two cycles per vector
    run_wait(3, 100, cyc);
    check("nosettle_cycles", cyc, 8);
    check("nosettle_pass",   32'(pass_v[3]), 1);
    check("nosettle_err",    32'(err_v[3]),  0);

    // Async reset in SETTLE of vector 10
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_a", 32'(a_v[0]), 1);
    check("pre_rst_b", 32'(b_v[0]), 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_a",    32'(a_v[0]),    0);
    check("async_rst_vec",  32'(vec_v[0]),  0);
    check("async_rst_busy", 32'(busy_v[0]), 0);
    check("async_rst_done", 32'(done_v[0]), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle_busy", 32'(busy_v[0]), 0);
    check("post_rst_idle_done", 32'(done_v[0]), 0);
    run_wait(0, 100, cyc);
    check("post_rst_cycles", cyc, 16);
    check("post_rst_pass",   32'(pass_v[0]), 1);
    check("post_rst_err",    32'(err_v[0]),  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
